// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   rx_state_e      : receive framer state encoding
//   PAR_NONE/EVEN/ODD : values accepted by the PARITY_MODE parameter
//   BIT_CNT_W       : width of the data/stop bit counter (covers up to 9 data bits)
//   parity_mismatch : parity check shared by any receiver using this package
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int BIT_CNT_W = 4;

  // The XOR of the data bits and the received parity bit is 0 for a correct
  // even-parity frame; odd parity expects the opposite, hence the extra term.
  function automatic logic parity_mismatch(input logic data_xor,
                                           input logic pbit,
                                           input int   mode);
    return data_xor ^ pbit ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_rx_bit_timer
// Oversample counter for the UART receiver. Counts sample_tick strobes from
// 0 to OVERSAMPLE-1 and flags the two sampling points the framer needs.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   sample_tick  in   one-cycle strobe at OVERSAMPLE x baud
//   restart      in   force the count back to 0 on the current tick
//   half_point   out  tick on which the count is OVERSAMPLE/2-1 (start-bit centre)
//   mid_bit      out  tick on which the count is OVERSAMPLE-1 (one full bit later)
// -----------------------------------------------------------------------------
module uart_rx_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_tick,
  input  logic restart,
  output logic half_point,
  output logic mid_bit
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] HALF_CNT = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] tick_cnt;

  // The counter only moves on a tick. A restart lands on the same tick that
  // caused it, so the first tick after a restart is seen as count 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (sample_tick) begin
      if (restart || (tick_cnt == LAST_CNT)) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_cnt + CW'(1);
      end
    end
  end

  assign half_point = sample_tick && (tick_cnt == HALF_CNT);
  assign mid_bit    = sample_tick && (tick_cnt == LAST_CNT);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
// Parametrised UART receive framer. Detects a start bit on the oversampled
// input, captures DATA_BITS data bits LSB first, optionally checks parity,
// checks STOP_BITS stop bits and presents the word on a valid/ready interface
// with parity, framing and overrun flags.
//
// Parameters:
//   DATA_BITS   data bits per frame (5..9)
//   PARITY_MODE 0 none, 1 even, 2 odd
//   STOP_BITS   stop bits checked (1 or 2)
//   OVERSAMPLE  sample_tick strobes per bit (even, >= 4)
//
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   sample_tick   one-cycle strobe at OVERSAMPLE x baud
//   rxd           synchronised serial input, idle high
//   rx_data       received word
//   rx_valid      word/flags valid, held until accepted
//   rx_ready      consumer accepts when rx_valid && rx_ready
//   parity_error  parity mismatch for the presented word
//   frame_error   a stop bit sampled low for the presented word
//   overrun       sticky: a frame completed while the previous word was unaccepted
//   busy          framer is not idle
//   break_det     one-cycle pulse when a break frame is seen
//
// Build option:
//   RX_BREAK_DETECT_EN  when defined, an all-zero frame raises break_det instead
//                       of delivering a word, and no new start is accepted until
//                       rxd has been sampled high again. When undefined,
//                       break_det is tied low and such a frame is delivered as
//                       a zero word with frame_error set.
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_error,
  output logic                 frame_error,
  output logic                 overrun,
  output logic                 busy,
  output logic                 break_det
);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  rx_state_e state;
  rx_state_e next_state;

  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 perr_acc;
  logic                 ferr_acc;

  logic restart;
  logic half_point;
  logic mid_bit;

  logic frame_begin;
  logic shift_en;
  logic par_en;
  logic stop_en;
  logic cnt_clr;
  logic frame_done;
  logic start_allowed;
  logic break_now;
  logic word_ferr;

  uart_rx_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .restart     (restart),
    .half_point  (half_point),
    .mid_bit     (mid_bit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and datapath controls. The timer is held at zero while idle so
  // the start-bit centre is always OVERSAMPLE/2 ticks after the falling edge,
  // and it is restarted once more at that centre so every later sample falls
  // exactly one bit period apart.
  always_comb begin
    next_state  = state;
    restart     = 1'b0;
    frame_begin = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_en     = 1'b0;
    cnt_clr     = 1'b0;
    frame_done  = 1'b0;
    unique case (state)
      IDLE: begin
        restart = 1'b1;
        if (sample_tick && !rxd && start_allowed) begin
          next_state = START;
        end
      end
      START: begin
        if (half_point) begin
          restart = 1'b1;
          cnt_clr = 1'b1;
          if (rxd) begin
            next_state = IDLE;
          end else begin
            frame_begin = 1'b1;
            next_state  = DATA;
          end
        end
      end
      DATA: begin
        if (mid_bit) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_DATA) begin
            cnt_clr    = 1'b1;
            next_state = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (mid_bit) begin
          par_en     = 1'b1;
          next_state = STOP;
        end
      end
      STOP: begin
        if (mid_bit) begin
          stop_en = 1'b1;
          if (bit_cnt == LAST_STOP) begin
            cnt_clr    = 1'b1;
            frame_done = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // Bit counter, LSB-first shift register and per-frame error accumulators.
  // The accumulators are cleared when a start bit is confirmed, so a frame
  // abandoned by a glitch or reset never leaks flags into the next word.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      perr_acc  <= 1'b0;
      ferr_acc  <= 1'b0;
    end else begin
      if (cnt_clr) begin
        bit_cnt <= '0;
      end else if (shift_en || stop_en) begin
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
      if (shift_en) begin
        shift_reg <= {rxd, shift_reg[DATA_BITS-1:1]};
      end
      if (frame_begin) begin
        perr_acc <= 1'b0;
        ferr_acc <= 1'b0;
      end else begin
        if (par_en) begin
          perr_acc <= parity_mismatch(^shift_reg, rxd, PARITY_MODE);
        end
        if (stop_en && !rxd) begin
          ferr_acc <= 1'b1;
        end
      end
    end
  end

  // The final stop sample is live on rxd during the completing tick, so it is
  // folded in here rather than waiting a cycle for the accumulator.
  assign word_ferr = ferr_acc | ~rxd;

`ifdef RX_BREAK_DETECT_EN
  logic zero_acc;
  logic brk_hold;

  // zero_acc stays set only while every sample of the frame has been low.
  // brk_hold blocks start detection after a break until the line returns high.
  always_ff @(posedge clk) begin
    if (reset) begin
      zero_acc  <= 1'b0;
      brk_hold  <= 1'b0;
      break_det <= 1'b0;
    end else begin
      if (frame_begin) begin
        zero_acc <= 1'b1;
      end else if ((shift_en || par_en || stop_en) && rxd) begin
        zero_acc <= 1'b0;
      end
      if (break_now) begin
        brk_hold <= 1'b1;
      end else if ((state == IDLE) && sample_tick && rxd) begin
        brk_hold <= 1'b0;
      end
      break_det <= break_now;
    end
  end

  assign break_now     = frame_done && zero_acc && !rxd;
  assign start_allowed = !brk_hold;
`else
  assign break_now     = 1'b0;
  assign start_allowed = 1'b1;
  assign break_det     = 1'b0;
`endif

  // Output register. A completed frame replaces the presented word if the slot
  // is empty or being accepted in the same cycle; otherwise the old word is kept
  // and the loss is recorded in the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
    end else if (frame_done && !break_now) begin
      if (!rx_valid || rx_ready) begin
        rx_data      <= shift_reg;
        parity_error <= perr_acc;
        frame_error  <= word_ferr;
        rx_valid     <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid     <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame_ctrl
// Directed bench for uart_rx_frame_ctrl at DATA_BITS=8, even parity, one stop
// bit, 16x oversampling. A table of frames with hand-computed results drives
// the main receive path; hand-written sequences cover latency, glitch rejection,
// overrun, reset mid-frame and the break frame (both builds of
// RX_BREAK_DETECT_EN).
// -----------------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;

  logic       clk;
  logic       reset;
  logic       sample_tick;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_error;
  logic       frame_error;
  logic       overrun;
  logic       busy;
  logic       break_det;

  int n_compared;
  int n_mismatched;

  int         cap_count;
  int         brk_count;
  logic [7:0] cap_data;
  logic       cap_perr;
  logic       cap_ferr;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       stopb;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[6];

  uart_rx_frame_ctrl #(
    .DATA_BITS   (8),
    .PARITY_MODE (1),
    .STOP_BITS   (1),
    .OVERSAMPLE  (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .busy         (busy),
    .break_det    (break_det)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every accepted word and every break pulse, sampled just after the
  // falling edge so it sees the inputs the next rising edge will act on.
  initial begin
    cap_count = 0;
    brk_count = 0;
    cap_data  = 8'h00;
    cap_perr  = 1'b0;
    cap_ferr  = 1'b0;
  end

  always @(negedge clk) begin
    #1;
    if (rx_valid && rx_ready) begin
      cap_count = cap_count + 1;
      cap_data  = rx_data;
      cap_perr  = parity_error;
      cap_ferr  = frame_error;
    end
    if (break_det) begin
      brk_count = brk_count + 1;
    end
  end

  // Bench-wide bound so a stuck run still ends with a report.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish before 3 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared = n_compared + 1;
    if (actual !== expected) begin
      n_mismatched = n_mismatched + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One tick per two clocks; rxd changes together with the tick strobe.
  task automatic levelTicks(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rxd         = lvl;
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  endtask

  // Sends tick positions [from, to) of an 11-bit frame (16 ticks per bit).
  task automatic sendRange(input logic [7:0] d, input logic pbit, input logic stopb,
                           input int from, input int to);
    logic [10:0] bits;
    bits = {stopb, pbit, d, 1'b0};
    for (int i = from; i < to; i++) begin
      @(negedge clk);
      rxd         = bits[i / 16];
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  endtask

  // Full frame followed by a bit time of idle line.
  task automatic applyStimulus(input vec_t v);
    sendRange(v.data, v.pbit, v.stopb, 0, 176);
    levelTicks(1'b1, 16);
  endtask

  task automatic checkVector(input vec_t v, input int prev_count, input string tag);
    checkOutput({tag, " words"}, 32'(cap_count - prev_count), 32'd1);
    checkOutput({tag, " rx_data"}, 32'(cap_data), 32'(v.exp_data));
    checkOutput({tag, " parity_error"}, 32'(cap_perr), 32'(v.exp_perr));
    checkOutput({tag, " frame_error"}, 32'(cap_ferr), 32'(v.exp_ferr));
  endtask

  initial begin
    int   prev;
    int   prev_brk;
    vec_t v;

    n_compared   = 0;
    n_mismatched = 0;

    // Even parity: pbit makes the total count of ones even.
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1};
    vecs[3] = '{8'h7E, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};

    reset       = 1'b1;
    sample_tick = 1'b0;
    rxd         = 1'b1;
    rx_ready    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] reset state");
    checkOutput("reset flags", 32'({rx_valid, parity_error, frame_error, overrun, busy, break_det}), 32'd0);
    checkOutput("reset rx_data", 32'(rx_data), 32'd0);

    levelTicks(1'b1, 8);

    $display("[TB] table frames");
    for (int i = 0; i < 6; i++) begin
      prev = cap_count;
      applyStimulus(vecs[i]);
      checkVector(vecs[i], prev, $sformatf("vec%0d", i));
    end

    $display("[TB] completion latency");
    prev = cap_count;
    sendRange(8'h96, 1'b0, 1'b1, 0, 168);
    checkOutput("pre-stop rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("pre-stop busy", 32'(busy), 32'd1);
    sendRange(8'h96, 1'b0, 1'b1, 168, 169);
    checkOutput("post-stop rx_valid", 32'(rx_valid), 32'd1);
    checkOutput("post-stop rx_data", 32'(rx_data), 32'h96);
    checkOutput("post-stop busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("valid one clk", 32'(rx_valid), 32'd0);
    sendRange(8'h96, 1'b0, 1'b1, 169, 176);
    levelTicks(1'b1, 16);
    checkOutput("latency words", 32'(cap_count - prev), 32'd1);

    $display("[TB] start glitch");
    prev = cap_count;
    levelTicks(1'b0, 4);
    checkOutput("glitch busy low", 32'(busy), 32'd1);
    levelTicks(1'b1, 4);
    checkOutput("glitch busy pre-sample", 32'(busy), 32'd1);
    levelTicks(1'b1, 1);
    checkOutput("glitch busy after", 32'(busy), 32'd0);
    levelTicks(1'b1, 16);
    checkOutput("glitch words", 32'(cap_count - prev), 32'd0);

    $display("[TB] overrun");
    prev = cap_count;
    @(negedge clk);
    rx_ready = 1'b0;
    sendRange(8'h11, 1'b0, 1'b1, 0, 176);
    sendRange(8'h22, 1'b0, 1'b1, 0, 176);
    levelTicks(1'b1, 16);
    checkOutput("overrun rx_valid", 32'(rx_valid), 32'd1);
    checkOutput("overrun rx_data", 32'(rx_data), 32'h11);
    checkOutput("overrun flag", 32'(overrun), 32'd1);
    checkOutput("overrun words", 32'(cap_count - prev), 32'd0);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    checkOutput("accept rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("accept overrun", 32'(overrun), 32'd0);
    checkOutput("accept data", 32'(cap_data), 32'h11);
    checkOutput("accept words", 32'(cap_count - prev), 32'd1);

    $display("[TB] reset mid-frame");
    v = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    applyStimulus(v);
    checkOutput("held parity_error", 32'(parity_error), 32'd1);
    sendRange(8'h3C, 1'b1, 1'b1, 0, 68);
    checkOutput("mid-frame busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid reset flags", 32'({rx_valid, parity_error, frame_error, overrun, busy, break_det}), 32'd0);
    checkOutput("mid reset rx_data", 32'(rx_data), 32'd0);
    rx_ready = 1'b1;
    levelTicks(1'b1, 20);
    prev = cap_count;
    v = '{8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    applyStimulus(v);
    checkVector(v, prev, "after reset");

    $display("[TB] break frame");
    prev     = cap_count;
    prev_brk = brk_count;
`ifdef RX_BREAK_DETECT_EN
    sendRange(8'h00, 1'b0, 1'b0, 0, 176);
    checkOutput("break pulses", 32'(brk_count - prev_brk), 32'd1);
    checkOutput("break words", 32'(cap_count - prev), 32'd0);
    levelTicks(1'b0, 20);
    checkOutput("break hold busy", 32'(busy), 32'd0);
    checkOutput("break single pulse", 32'(brk_count - prev_brk), 32'd1);
    levelTicks(1'b1, 16);
    prev = cap_count;
    v = '{8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
    applyStimulus(v);
    checkVector(v, prev, "after break");
`else
    v = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    applyStimulus(v);
    checkVector(v, prev, "break frame");
    checkOutput("break_det tied", 32'(brk_count - prev_brk), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
